// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states, opcodes,
// datapath mux selects and the per-state control word.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // fetch marks the state whose ir_write/pc_update wait on mem_ready
    typedef struct packed {
        logic       fetch;
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.fetch      = 1'b1;
                c.pc_update  = 1'b1;
                c.ir_write   = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
            end
            MEMREAD:  c.adr_src = 1'b1;
            MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            EXECR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = ALUOP_FUNCT;
            end
            EXECI: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
            ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            BEQ: begin
                c.alu_src_a  = SRCA_RD1;
                c.alu_src_b  = SRCB_RD2;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU-control decoder: maps ALUOp plus instruction function fields to the
// 3-bit ALU operation.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7_5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // only R-type distinguishes sub; addi's instr[30] is immediate data
                    3'b000:  alu_control = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RISC-V core, with a memory-ready
// handshake on the shared instruction/data memory.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int OP_W = 7
)(
    input  logic            clk,
    input  logic            reset_n,
    input  logic [OP_W-1:0] op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            adr_src,
    output logic            mem_write,
    output logic            ir_write,
    output logic [1:0]      result_src,
    output logic [1:0]      alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic            reg_write,
    output logic [1:0]      imm_src,
    output logic [2:0]      alu_control,
    output logic            illegal_instr
);

    state_t state, state_nxt;
    ctrl_t  ctrl_q, ctrl;
    logic   op_legal;

    always_comb begin
        op_legal = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:    state_nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_R:         state_nxt = EXECR;
                    OP_I:         state_nxt = EXECI;
                    OP_JAL:       state_nxt = JAL;
                    OP_BEQ:       state_nxt = BEQ;
                    default:      state_nxt = FETCH;
                endcase
            end
            MEMADR:   state_nxt = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  state_nxt = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    state_nxt = FETCH;
            MEMWRITE: state_nxt = mem_ready ? FETCH : MEMWRITE;
            EXECR:    state_nxt = ALUWB;
            EXECI:    state_nxt = ALUWB;
            JAL:      state_nxt = ALUWB;
            ALUWB:    state_nxt = FETCH;
            BEQ:      state_nxt = FETCH;
            default:  state_nxt = FETCH;
        endcase
    end

    // Control word is registered alongside the state so outputs come straight from flops
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= FETCH;
            ctrl_q <= state_ctrl(FETCH);
        end else begin
            state  <= state_nxt;
            ctrl_q <= state_ctrl(state_nxt);
        end
    end

    // Reset overrides immediately so nothing is written in the cycle reset is seen
    assign ctrl = reset_n ? ctrl_q : state_ctrl(FETCH);

    assign adr_src    = ctrl.adr_src;
    assign result_src = ctrl.result_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;

    assign ir_write      = reset_n & ctrl.ir_write & mem_ready;
    assign mem_write     = reset_n & ctrl.mem_write;
    assign reg_write     = reset_n & ctrl.reg_write;
    assign pc_write      = reset_n & ((ctrl.pc_update & (~ctrl.fetch | mem_ready))
                                      | (ctrl.branch & zero));
    assign illegal_instr = reset_n & (state == DECODE) & ~op_legal;

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (ctrl.alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7_5    (funct7_5),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Cycle-by-cycle vector bench for multicycle_controller with a queued
// scoreboard, plus a randomized-stall lw latency sequence.
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] ILL = 7'b1110011;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] op = RT;
    logic [2:0] funct3 = 3'b000;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    int total = 0;
    int passed = 0;

    multicycle_controller dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .op            (op),
        .funct3        (funct3),
        .funct7_5      (funct7_5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .reg_write     (reg_write),
        .imm_src       (imm_src),
        .alu_control   (alu_control),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    // exp = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
    //        alu_src_b, reg_write, imm_src, alu_control, illegal_instr}
    typedef struct {
        string       name;
        logic        rst_n;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic        mr;
        logic [16:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [16:0] exp_q[$];

    function automatic vec_t v(input string name, input int rst, input logic [6:0] o,
                               input int f3, input int f7, input int z, input int mr,
                               input int pcw, input int adr, input int mw, input int irw,
                               input int rs, input int sa, input int sb, input int rw,
                               input int imm, input int alu, input int ill);
        vec_t t;
        t.name  = name;
        t.rst_n = 1'(rst);
        t.op    = o;
        t.f3    = 3'(f3);
        t.f7    = 1'(f7);
        t.z     = 1'(z);
        t.mr    = 1'(mr);
        t.exp   = {1'(pcw), 1'(adr), 1'(mw), 1'(irw), 2'(rs), 2'(sa), 2'(sb),
                   1'(rw), 2'(imm), 3'(alu), 1'(ill)};
        return t;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endtask

    task automatic apply(input vec_t t);
        logic [16:0] got, want;
        @(posedge clk); #1;
        reset_n   = t.rst_n;
        op        = t.op;
        funct3    = t.f3;
        funct7_5  = t.f7;
        zero      = t.z;
        mem_ready = t.mr;
        exp_q.push_back(t.exp);
        @(negedge clk);
        got  = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, reg_write, imm_src, alu_control, illegal_instr};
        want = exp_q.pop_front();
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h expected %h", t.name, got, want);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int stall, left, gap, adr_cycles;
        bit done;

        //                       rst op  f3 f7 z mr  pcw adr mw irw rs sa sb rw imm alu ill
        vecs.push_back(v("rst0",    0, RT, 0, 0, 0, 1,  0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0));
        vecs.push_back(v("rst1",    0, RT, 0, 0, 0, 1,  0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0));
        vecs.push_back(v("add_f",   1, RT, 0, 0, 0, 1,  1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0));
        vecs.push_back(v("add_d",   1, RT, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(v("add_x",   1, RT, 0, 0, 0, 1,  0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));
        vecs.push_back(v("add_wb",  1, RT, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(v("sub_f",   1, RT, 0, 1, 0, 1,  1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0));
        vecs.push_back(v("sub_d",   1, RT, 0, 1, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(v("sub_x",   1, RT, 0, 1, 0, 1,  0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 0));
        vecs.push_back(v("sub_wb",  1, RT, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(v("and_f",   1, RT, 7, 0, 0, 1,  1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0));
        vecs.push_back(v("and_d",   1, RT, 7, 0, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(v("and_x",   1, RT, 7, 0, 0, 1,  0, 0, 0, 0, 0, 2, 0, 0, 0, 2, 0));
        vecs.push_back(v("and_wb",  1, RT, 7, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(v("slt_f",   1, RT, 2, 0, 0, 1,  1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0));
        vecs.push_back(v("slt_d",   1, RT, 2, 0, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(v("slt_x",   1, RT, 2, 0, 0, 1,  0, 0, 0, 0, 0, 2, 0, 0, 0, 5, 0));
        vecs.push_back(v("slt_wb",  1, RT, 2, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(v("addi_f",  1, IT, 0, 1, 0, 1,  1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0));
        vecs.push_back(v("addi_d",  1, IT, 0, 1, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(v("addi_x",  1, IT, 0, 1, 0, 1,  0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
        vecs.push_back(v("addi_wb", 1, IT, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(v("ori_f",   1, IT, 6, 0, 0, 1,  1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0));
        vecs.push_back(v("ori_d",   1, IT, 6, 0, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(v("ori_x",   1, IT, 6, 0, 0, 1,  0, 0, 0, 0, 0, 2, 1, 0, 0, 3, 0));
        vecs.push_back(v("ori_wb",  1, IT, 6, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(v("lw_f",    1, LW, 2, 0, 0, 1,  1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0));
        vecs.push_back(v("lw_d",    1, LW, 2, 0, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(v("lw_ma",   1, LW, 2, 0, 0, 1,  0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
        vecs.push_back(v("lw_mr0",  1, LW, 2, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v("lw_mr1",  1, LW, 2, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v("lw_mr2",  1, LW, 2, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v("lw_mr3",  1, LW, 2, 0, 0, 1,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v("lw_wb",   1, LW, 2, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        vecs.push_back(v("sw_f",    1, SW, 2, 0, 0, 1,  1, 0, 0, 1, 2, 0, 2, 0, 1, 0, 0));
        vecs.push_back(v("sw_d",    1, SW, 2, 0, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
        vecs.push_back(v("sw_ma",   1, SW, 2, 0, 0, 1,  0, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0));
        vecs.push_back(v("sw_mw0",  1, SW, 2, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v("sw_mw1",  1, SW, 2, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v("sw_mw2",  1, SW, 2, 0, 0, 1,  0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v("f_wait",  1, SW, 2, 0, 0, 0,  0, 0, 0, 0, 2, 0, 2, 0, 1, 0, 0));
        vecs.push_back(v("beq_f",   1, BQ, 0, 0, 1, 1,  1, 0, 0, 1, 2, 0, 2, 0, 2, 0, 0));
        vecs.push_back(v("beq_d",   1, BQ, 0, 0, 1, 1,  0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0));
        vecs.push_back(v("beq_tk",  1, BQ, 0, 0, 1, 1,  1, 0, 0, 0, 0, 2, 0, 0, 2, 1, 0));
        vecs.push_back(v("beq2_f",  1, BQ, 0, 0, 0, 1,  1, 0, 0, 1, 2, 0, 2, 0, 2, 0, 0));
        vecs.push_back(v("beq2_d",  1, BQ, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0));
        vecs.push_back(v("beq_nt",  1, BQ, 0, 0, 0, 1,  0, 0, 0, 0, 0, 2, 0, 0, 2, 1, 0));
        vecs.push_back(v("jal_f",   1, JL, 0, 0, 0, 1,  1, 0, 0, 1, 2, 0, 2, 0, 3, 0, 0));
        vecs.push_back(v("jal_d",   1, JL, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 3, 0, 0));
        vecs.push_back(v("jal_j",   1, JL, 0, 0, 0, 1,  1, 0, 0, 0, 0, 1, 2, 0, 3, 0, 0));
        vecs.push_back(v("jal_wb",  1, JL, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0));
        vecs.push_back(v("ill_f",   1, ILL, 0, 0, 0, 1, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0));
        vecs.push_back(v("ill_d",   1, ILL, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
        vecs.push_back(v("rsw_f",   1, SW, 0, 0, 0, 1,  1, 0, 0, 1, 2, 0, 2, 0, 1, 0, 0));
        vecs.push_back(v("rsw_d",   1, SW, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
        vecs.push_back(v("rsw_ma",  1, SW, 0, 0, 0, 1,  0, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0));
        vecs.push_back(v("rsw_mw",  1, SW, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v("rsw_rst", 0, SW, 0, 0, 0, 0,  0, 0, 0, 0, 2, 0, 2, 0, 1, 0, 0));
        vecs.push_back(v("rsw_f2",  1, SW, 0, 0, 0, 1,  1, 0, 0, 1, 2, 0, 2, 0, 1, 0, 0));
        vecs.push_back(v("rsw_d2",  1, SW, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));

        foreach (vecs[i]) apply(vecs[i]);

        // lw with a random number of memory stall cycles in MEMREAD
        @(posedge clk); #1;
        reset_n = 1'b0; op = LW; funct3 = 3'b010; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("lat_fetch_ir", int'(ir_write), 1);
        stall = int'($urandom_range(1, 4));
        left = stall; gap = 0; adr_cycles = 0; done = 1'b0;
        for (int c = 1; c < 40 && !done; c++) begin
            @(posedge clk); #1;
            mem_ready = !(adr_src && left > 0);
            if (adr_src) begin
                adr_cycles++;
                if (left > 0) left--;
            end
            @(negedge clk);
            if (ir_write) begin
                gap = c;
                done = 1'b1;
            end
        end
        chk("lw_stall_latency", gap, 5 + stall);
        chk("lw_memread_cycles", adr_cycles, 1 + stall);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control unit for the multicycle RISC-V core. Sequences one instruction at a time through Fetch/Decode/Execute/Memory/Writeback states.
- Drives every datapath mux select and write enable. Generates ALUOp and feeds it to the ALU-control decoder to produce ALUControl.
- Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.
- Adds a memory-ready handshake so the shared instruction/data memory may take several cycles.

Parameters:
- OP_W, 7, opcode width
- RESET_STATE_FETCH, 1, fixed, documentation only: reset always enters FETCH

Ports:
- clk  in  1  core clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  0=PC, 1=ALUOut to memory address
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register / OldPC enable
- result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rd1
- alu_src_b  out  2  00=rd2, 01=ImmExt, 10=constant 4
- reg_write  out  1  register file write enable
- imm_src  out  2  00=I, 01=S, 10=B, 11=J
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_instr  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- Moore FSM. State register updates on rising clk.
- reset_n=0 at a rising edge forces state=FETCH.
- While reset_n=0, pc_write, ir_write, mem_write, reg_write and illegal_instr are forced 0 combinationally. Other outputs take their FETCH values.
- Reset mid-instruction abandons that instruction. No partial writes occur after the reset edge.
- Outputs not listed for a state are 0. ALUOp defaults to 00.
- FETCH:
  - adr_src=0, alu_src_a=00, alu_src_b=10, ALUOp=00, result_src=10.
  - ir_write=mem_ready, pc_update=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=01, alu_src_b=01, ALUOp=00 (branch target precompute).
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 -> BEQ.
  - Any other op -> FETCH, with illegal_instr=1 for this cycle.
- MEMADR: alu_src_a=10, alu_src_b=01, ALUOp=00. If op[5]=1 go to MEMWRITE, else MEMREAD.
- MEMREAD: adr_src=1. Stay while mem_ready=0; then go to MEMWB.
- MEMWB: result_src=01, reg_write=1. Then go to FETCH.
- MEMWRITE: adr_src=1, mem_write=1, held asserted until mem_ready=1. Then go to FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, ALUOp=10. Then go to ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, ALUOp=10. Then go to ALUWB.
- JAL: alu_src_a=01, alu_src_b=10, ALUOp=00, result_src=00, pc_update=1. Then go to ALUWB.
- ALUWB: result_src=00, reg_write=1. Then go to FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, ALUOp=01, result_src=00, branch=1. Then go to FETCH.
- pc_write = pc_update | (branch & zero).
- imm_src is a pure function of op: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, else 00.
- alu_control is a pure function of ALUOp, funct3, op[5], funct7_5:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10, funct3 000 -> sub only when op[5]=1 and funct7_5=1, else add.
  - ALUOp 10, funct3 010 -> slt; 110 -> or; 111 -> and.
  - Other funct3 -> 000.
- Instruction latency with mem_ready always 1:
  - lw 5 cycles; sw, R-type, I-type, jal 4 cycles; beq 3 cycles; illegal 2 cycles.
- Each cycle of mem_ready=0 adds one cycle in FETCH, MEMREAD or MEMWRITE.
- Unused state encodings decode to FETCH on the next clock.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ.
  - Opcode localparams: OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ.
  - ALUOp, result_src, src_a, src_b and imm_src encodings as localparams.
- The existing alu_decoder is instantiated as the sole sub-module for alu_control.
- The FSM and imm_src decode stay in this module.

Test Plan:
- reset_n=0 for 2 cycles with op=0110011 -> write enables all 0. First cycle after release is FETCH with alu_src_b=10, result_src=10.
- add (op=0110011, funct3=000, funct7_5=0), mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB.
  - alu_control=000 in EXECR; reg_write=1 only in ALUWB.
  - Repeat with funct7_5=1 -> alu_control=001.
- lw (op=0000011) with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles with adr_src=1, then MEMWB with result_src=01, reg_write=1. Total 8 cycles.
- sw (op=0100011), mem_ready=0 for 2 cycles -> imm_src=01 and mem_write=1 for 3 consecutive cycles, then FETCH.
- beq (op=1100011), zero=1 vs zero=0 -> pc_write=1 vs 0 in BEQ, alu_control=001, imm_src=10. 3-cycle instruction.
- op=1110011 -> illegal_instr pulses in DECODE, next state FETCH, no reg_write or mem_write. Also: reset_n=0 during MEMWRITE -> mem_write=0 immediately, FETCH next cycle.
